// File: rtl/rsa_cmd_ctrl.sv
// Command sequencer between the ARM port set and the RSA core: decodes commands, moves operand/result, launches the core.
// Define RSA_CMD_LOOPBACK_EN to bypass the core (COMPUTE copies the operand register into the result register).
module rsa_cmd_ctrl #(
  parameter int DATA_W = 1024,
  parameter int CMD_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CMD_W-1:0]  arm_to_fpga_cmd,
  input  logic              arm_to_fpga_cmd_valid,
  output logic              fpga_to_arm_done,
  input  logic              fpga_to_arm_done_read,
  input  logic              arm_to_fpga_data_valid,
  output logic              arm_to_fpga_data_ready,
  input  logic [DATA_W-1:0] arm_to_fpga_data,
  output logic              fpga_to_arm_data_valid,
  input  logic              fpga_to_arm_data_ready,
  output logic [DATA_W-1:0] fpga_to_arm_data,
  output logic              core_start,
  output logic [DATA_W-1:0] core_operand,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic [3:0]        leds
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RX_DATA    = 3'd1,
    ST_CORE_START = 3'd2,
    ST_CORE_WAIT  = 3'd3,
    ST_TX_DATA    = 3'd4,
    ST_DONE       = 3'd5
  } state_e;

  localparam logic [CMD_W-1:0] CMD_READ    = CMD_W'(0);
  localparam logic [CMD_W-1:0] CMD_COMPUTE = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_WRITE   = CMD_W'(2);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] in_q, in_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              bad_q, bad_d;

  // State and buffer registers; the operand/result buffers are cleared by reset too.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      in_q    <= '0;
      out_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      out_q   <= out_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    out_d   = out_q;
    bad_d   = bad_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arm_to_fpga_cmd_valid) begin
          unique case (arm_to_fpga_cmd)
            CMD_READ:    state_d = ST_RX_DATA;
            CMD_COMPUTE: state_d = ST_CORE_START;
            CMD_WRITE:   state_d = ST_TX_DATA;
            default: begin
              state_d = ST_DONE;
              bad_d   = 1'b1;
            end
          endcase
        end
      end
      ST_RX_DATA: begin
        if (arm_to_fpga_data_valid) begin
          in_d    = arm_to_fpga_data;
          state_d = ST_DONE;
        end
      end
      ST_CORE_START: begin
`ifdef RSA_CMD_LOOPBACK_EN
        out_d   = in_q;
        state_d = ST_DONE;
`else
        state_d = ST_CORE_WAIT;
`endif
      end
      // Unreachable in loopback builds, so core_done has no effect there.
      ST_CORE_WAIT: begin
        if (core_done) begin
          out_d   = core_result;
          state_d = ST_DONE;
        end
      end
      ST_TX_DATA: begin
        if (fpga_to_arm_data_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (fpga_to_arm_done_read) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs: decoded from registered state only.
  always_comb begin
    arm_to_fpga_data_ready = 1'b0;
    fpga_to_arm_data_valid = 1'b0;
    fpga_to_arm_done       = 1'b0;
    core_start             = 1'b0;
    unique case (state_q)
      ST_RX_DATA:    arm_to_fpga_data_ready = 1'b1;
      ST_TX_DATA:    fpga_to_arm_data_valid = 1'b1;
      ST_DONE:       fpga_to_arm_done       = 1'b1;
      ST_CORE_START: begin
`ifdef RSA_CMD_LOOPBACK_EN
        core_start = 1'b0;
`else
        core_start = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  assign fpga_to_arm_data = out_q;
  assign core_operand     = in_q;
  assign leds             = {bad_q, state_q};

endmodule

// File: tb/tb_rsa_cmd_ctrl.sv
// Randomized self-checking bench for rsa_cmd_ctrl against a transaction-level model of operand/result/flag state.
module tb_rsa_cmd_ctrl;
  localparam int DATA_W = 1024;
  localparam int CMD_W  = 32;
  typedef logic [DATA_W-1:0] word_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [CMD_W-1:0]  cmd;
  logic              cmd_valid;
  logic              done;
  logic              done_read;
  logic              rx_valid;
  logic              rx_ready;
  word_t             rx_data;
  logic              tx_valid;
  logic              tx_ready;
  word_t             tx_data;
  logic              core_start;
  word_t             core_operand;
  logic              core_done;
  word_t             core_result;
  logic [3:0]        leds;

  rsa_cmd_ctrl #(.DATA_W(DATA_W), .CMD_W(CMD_W)) dut (
    .clk(clk), .rst(rst),
    .arm_to_fpga_cmd(cmd), .arm_to_fpga_cmd_valid(cmd_valid),
    .fpga_to_arm_done(done), .fpga_to_arm_done_read(done_read),
    .arm_to_fpga_data_valid(rx_valid), .arm_to_fpga_data_ready(rx_ready),
    .arm_to_fpga_data(rx_data),
    .fpga_to_arm_data_valid(tx_valid), .fpga_to_arm_data_ready(tx_ready),
    .fpga_to_arm_data(tx_data),
    .core_start(core_start), .core_operand(core_operand),
    .core_done(core_done), .core_result(core_result),
    .leds(leds)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_err = 0;
  word_t in_m, out_m;
  logic  bad_m;
`ifdef RSA_CMD_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif
  int    exp_starts = 0;
  int    exp_dones  = 0;
  int    starts_seen = 0;
  int    dones_seen  = 0;
  logic  done_prev = 1'b0;

  always @(posedge clk) begin
    done_prev <= done;
    if (core_start === 1'b1) starts_seen <= starts_seen + 1;
    if (done === 1'b1 && done_prev !== 1'b1) dones_seen <= dones_seen + 1;
  end

  task automatic check(input string tag, input word_t got, input word_t exp);
    int k;
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      k = 0;
      for (int i = 0; i < DATA_W / 64; i++) begin
        if (got[i*64 +: 64] !== exp[i*64 +: 64]) begin
          k = i;
          break;
        end
      end
      $display("FAIL %s: got[%0d+:64]=%h required %h", tag, k * 64, got[k*64 +: 64], exp[k*64 +: 64]);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [2:0] st, input logic e_done,
                         input logic e_rdy, input logic e_vld, input logic e_start);
    check({tag, "_leds"},  word_t'(leds),       word_t'({bad_m, st}));
    check({tag, "_done"},  word_t'(done),       word_t'(e_done));
    check({tag, "_ready"}, word_t'(rx_ready),   word_t'(e_rdy));
    check({tag, "_valid"}, word_t'(tx_valid),   word_t'(e_vld));
    check({tag, "_start"}, word_t'(core_start), word_t'(e_start));
  endtask

  task automatic chk_regs(input string tag);
    check({tag, "_operand"}, core_operand, in_m);
    check({tag, "_result"},  tx_data,      out_m);
  endtask

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Randomize every input that the current state must ignore.
  task automatic drive_noise(input bit busy);
    cmd_valid   = busy ? 1'($urandom) : 1'b0;
    cmd         = $urandom;
    rx_valid    = 1'($urandom);
    rx_data     = rand_word();
    tx_ready    = 1'($urandom);
    core_done   = 1'($urandom);
    core_result = rand_word();
    done_read   = 1'b0;
  endtask

  task automatic issue(input logic [CMD_W-1:0] c);
    chk_ctl("idle", 3'd0, 0, 0, 0, 0);
    drive_noise(1'b0);
    cmd       = c;
    cmd_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic finish_done(input int h);
    for (int i = 0; i < h; i++) begin
      chk_ctl("done_hold", 3'd5, 1, 0, 0, 0);
      drive_noise(1'b1);
      @(negedge clk);
    end
    chk_ctl("done_last", 3'd5, 1, 0, 0, 0);
    chk_regs("done");
    drive_noise(1'b1);
    done_read = 1'b1;
    @(negedge clk);
    drive_noise(1'b0);
    chk_ctl("after_done", 3'd0, 0, 0, 0, 0);
  endtask

  task automatic do_read(input word_t v, input int d, input int h);
    issue(CMD_W'(0));
    for (int i = 0; i < d; i++) begin
      chk_ctl("rx_stall", 3'd1, 0, 1, 0, 0);
      drive_noise(1'b1);
      rx_valid = 1'b0;
      @(negedge clk);
    end
    chk_ctl("rx_accept", 3'd1, 0, 1, 0, 0);
    drive_noise(1'b1);
    rx_valid = 1'b1;
    rx_data  = v;
    @(negedge clk);
    in_m = v;
    exp_dones++;
    finish_done(h);
  endtask

  task automatic do_compute(input int lat, input int h);
    issue(CMD_W'(1));
    chk_ctl("cstart", 3'd2, 0, 0, 0, !LOOPBACK);
    drive_noise(1'b1);
    @(negedge clk);
    if (LOOPBACK) begin
      out_m = in_m;
    end else begin
      exp_starts++;
      for (int i = 0; i < lat; i++) begin
        chk_ctl("cwait", 3'd3, 0, 0, 0, 0);
        drive_noise(1'b1);
        core_done = 1'b0;
        @(negedge clk);
      end
      chk_ctl("cwait_end", 3'd3, 0, 0, 0, 0);
      drive_noise(1'b1);
      core_done   = 1'b1;
      core_result = core_operand + 1'b1;
      @(negedge clk);
      out_m = in_m + 1'b1;
    end
    exp_dones++;
    finish_done(h);
  endtask

  task automatic do_write(input int d, input int h);
    issue(CMD_W'(2));
    for (int i = 0; i < d; i++) begin
      chk_ctl("tx_stall", 3'd4, 0, 0, 1, 0);
      check("tx_stall_data", tx_data, out_m);
      drive_noise(1'b1);
      tx_ready = 1'b0;
      @(negedge clk);
    end
    chk_ctl("tx_accept", 3'd4, 0, 0, 1, 0);
    check("tx_data", tx_data, out_m);
    drive_noise(1'b1);
    tx_ready = 1'b1;
    @(negedge clk);
    exp_dones++;
    finish_done(h);
  endtask

  task automatic do_bad(input logic [CMD_W-1:0] c, input int h);
    issue(c);
    bad_m = 1'b1;
    exp_dones++;
    check("bad_flag", word_t'(leds[3]), word_t'(1'b1));
    finish_done(h);
  endtask

  task automatic chk_after_reset(input string tag);
    in_m  = '0;
    out_m = '0;
    bad_m = 1'b0;
    chk_ctl(tag, 3'd0, 0, 0, 0, 0);
    chk_regs(tag);
  endtask

  task automatic reset_in_rx();
    issue(CMD_W'(0));
    chk_ctl("rrx", 3'd1, 0, 1, 0, 0);
    drive_noise(1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_noise(1'b0);
    chk_after_reset("rst_rx");
  endtask

  task automatic reset_in_wait(input int lat);
    issue(CMD_W'(1));
    drive_noise(1'b1);
    @(negedge clk);
    exp_starts++;
    for (int i = 0; i < lat; i++) begin
      chk_ctl("rcw", 3'd3, 0, 0, 0, 0);
      drive_noise(1'b1);
      core_done = 1'b0;
      @(negedge clk);
    end
    drive_noise(1'b1);
    core_done = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_noise(1'b0);
    chk_after_reset("rst_cw");
  endtask

  initial begin
    word_t v;
    int    s0, d0;
    logic [CMD_W-1:0] bc;
    in_m  = '0;
    out_m = '0;
    bad_m = 1'b0;
    rst   = 1'b1;
    drive_noise(1'b0);
    repeat (3) @(negedge clk);
    chk_after_reset("in_reset");
    rst = 1'b0;
    @(negedge clk);
    chk_after_reset("post_reset");

    // Write before any compute returns zero; bad command leaves buffers alone.
    do_write(0, 0);
    do_bad(CMD_W'(7), 0);
    do_read(rand_word(), 0, 1);
    do_bad(CMD_W'(32'hffff_fff3), 2);
    reset_in_rx();
    if (!LOOPBACK) begin
      do_read(rand_word(), 0, 0);
      do_bad(CMD_W'(3), 0);
      reset_in_wait(4);
    end

    // Round trip with the operand+1 stub.
    v  = word_t'(64'h0123_4567_89ab_cdef) << 640;
    s0 = starts_seen;
    d0 = dones_seen;
    do_read(v, 0, 0);
    do_compute(10, 0);
    do_write(0, 0);
    check("rt_result", tx_data, LOOPBACK ? v : v + 1'b1);
    check("rt_starts", word_t'(starts_seen - s0), word_t'(LOOPBACK ? 0 : 1));
    check("rt_dones",  word_t'(dones_seen - d0),  word_t'(3));

    if (LOOPBACK) begin
      do_read(word_t'(16'hDEAD), 0, 0);
      do_compute(0, 0);
      do_write(0, 0);
      check("lb_dead", tx_data, word_t'(16'hDEAD));
    end

    // Stalls, long done hold, fastest core response.
    do_read(rand_word(), 5, 20);
    do_write(7, 0);
    do_compute(0, 0);
    do_write(1, 3);

    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) begin
        chk_ctl("gap", 3'd0, 0, 0, 0, 0);
        drive_noise(1'b0);
        @(negedge clk);
      end
      case ($urandom_range(0, 3))
        0: do_read(rand_word(), $urandom_range(0, 3), $urandom_range(0, 3));
        1: do_compute($urandom_range(0, 6), $urandom_range(0, 3));
        2: do_write($urandom_range(0, 3), $urandom_range(0, 3));
        default: begin
          bc = $urandom;
          if (bc < 3) bc = bc + 3;
          do_bad(bc, $urandom_range(0, 3));
        end
      endcase
    end

    check("total_starts", word_t'(starts_seen), word_t'(exp_starts));
    check("total_dones",  word_t'(dones_seen),  word_t'(exp_dones));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rsa_cmd_ctrl.md
# rsa_cmd_ctrl

Command sequencer between the ARM-side port set and the RSA compute core, instantiated inside `rsa_wrapper`. It:
- decodes the 32-bit ARM command;
- runs the 1024-bit input/output handshakes;
- buffers one operand and one result;
- launches the core and waits for it;
- reports completion through a done/done_read handshake.

## Interface
Parameters:
- `DATA_W`, 1024: width of the operand, result and data buses.
- `CMD_W`, 32: command word width.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `arm_to_fpga_cmd` in CMD_W: command; 0=READ, 1=COMPUTE, 2=WRITE.
- `arm_to_fpga_cmd_valid` in 1: command strobe.
- `fpga_to_arm_done` out 1: command complete; held until acknowledged.
- `fpga_to_arm_done_read` in 1: done acknowledge.
- `arm_to_fpga_data_valid` in 1: input data valid.
- `arm_to_fpga_data_ready` out 1: input data accepted.
- `arm_to_fpga_data` in DATA_W: operand from ARM.
- `fpga_to_arm_data_valid` out 1: output data valid.
- `fpga_to_arm_data_ready` in 1: ARM ready to take output.
- `fpga_to_arm_data` out DATA_W: result to ARM; equals `out_reg`.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_operand` out DATA_W: equals `in_reg`.
- `core_done` in 1: one-cycle completion pulse from the core.
- `core_result` in DATA_W: core result; valid while `core_done`=1.
- `leds` out 4: [2:0] state code, [3] sticky bad-command flag.

## Operation
FSM states and codes: IDLE=0, RX_DATA=1, CORE_START=2, CORE_WAIT=3, TX_DATA=4, DONE=5.
- **IDLE:** on `cmd_valid`=1, decode the command.
  - READ goes to RX_DATA.
  - COMPUTE goes to CORE_START.
  - WRITE goes to TX_DATA.
  - Any other value goes to DONE and sets `leds[3]`.
- **RX_DATA:** `arm_to_fpga_data_ready`=1. On `valid && ready` at a clock edge, `in_reg` <= data, then go to DONE.
- **CORE_START:** `core_start`=1 for exactly this cycle, then go to CORE_WAIT.
- **CORE_WAIT:** on `core_done`=1, `out_reg` <= `core_result`, then go to DONE. No timeout.
- **TX_DATA:** `fpga_to_arm_data_valid`=1 and `fpga_to_arm_data` = `out_reg`. On `valid && ready`, go to DONE.
- **DONE:** `fpga_to_arm_done`=1. On `done_read`=1, go to IDLE.

Output and register rules:
- Every handshake output is a pure decode of the state register (Moore): no combinational path from inputs to outputs.
- `out_reg` persists across commands. WRITE without a prior COMPUTE returns the reset value 0.
- `in_reg` persists across commands. COMPUTE without a prior READ uses 0.
- `leds[3]` clears only on `rst`.

## Timing
- **Reset values:** all outputs 0, `in_reg`=0, `out_reg`=0, state IDLE. `rst` asserted in any state, including mid-compute, returns to IDLE on the next edge and drops every output. The core shares `rst`.
- **Command acceptance:** `cmd_valid` is sampled only in IDLE. Elsewhere it is ignored, with no queuing.
- **Data inputs:** `data_valid` is ignored outside RX_DATA. `fpga_to_arm_data_ready` is ignored outside TX_DATA.
- **Latencies, from the `cmd_valid` edge:**
  - READ: ready is high 1 cycle later. Done follows 1 cycle after the accepting edge.
  - COMPUTE: `core_start` 1 cycle later. Done 1 cycle after the `core_done` edge.
  - WRITE: valid 1 cycle later. Done 1 cycle after the accepting edge.
  - Bad command: done 1 cycle later.
- **Stalls:** if valid/ready is already high on entry, the transfer completes on the first cycle in the state. Otherwise the FSM stays in the state indefinitely.
- **Done handshake:** if `done_read` is high in the first DONE cycle, done lasts exactly 1 cycle. A `cmd_valid` in the same cycle as DONE→IDLE is not accepted.
- **Core timing:** a `core_done` outside CORE_WAIT is ignored. `core_done` arriving the cycle after `core_start` is legal.

## Configuration
- `RSA_CMD_LOOPBACK_EN` defined: CORE_START skips the core.
  - `core_start` stays 0.
  - `out_reg` <= `in_reg`, then go directly to DONE, so done comes 2 cycles after the COMPUTE command.
  - `core_done` is ignored.
- Undefined: normal core launch as described above.

## Test plan
- **Reset mid-compute:** assert `rst` in CORE_WAIT → next cycle state 0, all outputs 0, `out_reg`=0.
- **Round trip with a stub core:** stub returns operand+1 after 10 cycles. READ 0x0123456789abcdef<<640 → COMPUTE → WRITE.
  - Output is 0x0123456789abcdef<<640 + 1.
  - Exactly one `core_start` pulse.
  - Done asserted 3 times.
- **Stalled handshakes:**
  - READ with valid delayed 5 cycles → ready is held 5 cycles, accepts on the 6th.
  - WRITE with ready delayed 7 cycles → valid is held stable with constant data.
- **Done hold:** hold `done_read` low 20 cycles → done stays 1. Raise it → state 0 on the next edge.
- **Bad command and interference:**
  - Command 0x7 → done after 1 cycle, `leds[3]`=1, `in_reg`/`out_reg` unchanged.
  - `cmd_valid` pulses during CORE_WAIT → ignored.
- **Loopback** (with `RSA_CMD_LOOPBACK_EN`): READ 0xDEAD → COMPUTE → WRITE returns 0xDEAD, `core_start` never 1.
